// File: rtl/lvar_frame_alloc.sv
// rtl/lvar_frame_alloc.sv - local-variable frame allocator and identifier lookup engine
module lvar_frame_alloc #(
    parameter int DEPTH  = 16,
    parameter int NAME_W = 32,
    parameter int OFF_W  = 12,
    parameter int SIZE_W = 4,
    localparam int IW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [NAME_W-1:0] cmd_name,
    input  logic [SIZE_W-1:0] cmd_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [OFF_W-1:0]  rsp_offset,
    output logic [SIZE_W-1:0] rsp_size,
    output logic [IW-1:0]     rsp_index,
    output logic [CW-1:0]     count,
    output logic [OFF_W-1:0]  frame_size
);

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_DECL   = 2'b01;
    localparam logic [1:0] OP_LOOKUP = 2'b10;
    localparam logic [1:0] OP_RSV    = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NOTFND  = 2'b01;
    localparam logic [1:0] ST_DUP     = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

    state_t state, state_nxt;

    logic [1:0]        op_q;
    logic [NAME_W-1:0] name_q;
    logic [SIZE_W-1:0] size_q;
    logic [CW-1:0]     idx_q;
    logic              hit_q;
    logic [IW-1:0]     hit_idx_q;
    logic [CW-1:0]     count_q;
    logic [OFF_W-1:0]  frame_q;

    logic [NAME_W-1:0] tbl_name [DEPTH];
    logic [SIZE_W-1:0] tbl_size [DEPTH];
    logic [OFF_W-1:0]  tbl_off  [DEPTH];

    logic              scan_done;
    logic              entry_hit;
    logic [OFF_W:0]    new_off;
    logic              tbl_full;
    logic              tbl_we;

    // Scan termination, per-entry compare and the candidate allocation offset
    always_comb begin
        entry_hit = (idx_q != count_q) && (tbl_name[idx_q[IW-1:0]] == name_q);
        scan_done = (op_q == OP_CLEAR) || (op_q == OP_RSV) || (idx_q == count_q) ||
                    ((op_q == OP_LOOKUP) && hit_q);
        new_off   = {1'b0, frame_q} + {{(OFF_W + 1 - SIZE_W){1'b0}}, size_q};
        tbl_full  = (count_q == CNT_FULL);
        tbl_we    = (state == S_SCAN) && scan_done && (op_q == OP_DECL) &&
                    !hit_q && !tbl_full && !new_off[OFF_W];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic: accept, scan until done, hold response until taken
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_SCAN;
            S_SCAN:  if (scan_done) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Table storage; only a successful declare writes, so no reset is needed
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_name[count_q[IW-1:0]] <= name_q;
            tbl_size[count_q[IW-1:0]] <= size_q;
            tbl_off[count_q[IW-1:0]]  <= new_off[OFF_W-1:0];
        end
    end

    // Command latch, scan progress, frame bookkeeping and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= OP_CLEAR;
            name_q     <= '0;
            size_q     <= '0;
            idx_q      <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            count_q    <= '0;
            frame_q    <= '0;
            rsp_status <= ST_OK;
            rsp_offset <= '0;
            rsp_size   <= '0;
            rsp_index  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        name_q <= cmd_name;
                        size_q <= cmd_size;
                        idx_q  <= '0;
                        hit_q  <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (scan_done) begin
                        rsp_status <= ST_ILLEGAL;
                        rsp_offset <= '0;
                        rsp_size   <= '0;
                        rsp_index  <= '0;
                        case (op_q)
                            OP_CLEAR: begin
                                rsp_status <= ST_OK;
                                count_q    <= '0;
                                frame_q    <= '0;
                            end
                            OP_LOOKUP: begin
                                if (hit_q) begin
                                    rsp_status <= ST_OK;
                                    rsp_offset <= tbl_off[hit_idx_q];
                                    rsp_size   <= tbl_size[hit_idx_q];
                                    rsp_index  <= hit_idx_q;
                                end else begin
                                    rsp_status <= ST_NOTFND;
                                end
                            end
                            OP_DECL: begin
                                if (hit_q) begin
                                    rsp_status <= ST_DUP;
                                    rsp_offset <= tbl_off[hit_idx_q];
                                    rsp_size   <= tbl_size[hit_idx_q];
                                    rsp_index  <= hit_idx_q;
                                end else if (tbl_we) begin
                                    rsp_status <= ST_OK;
                                    rsp_offset <= new_off[OFF_W-1:0];
                                    rsp_size   <= size_q;
                                    rsp_index  <= count_q[IW-1:0];
                                    count_q    <= count_q + CNT_ONE;
                                    frame_q    <= new_off[OFF_W-1:0];
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        // first match wins; declare keeps scanning to the end
                        if (entry_hit && !hit_q) begin
                            hit_q     <= 1'b1;
                            hit_idx_q <= idx_q[IW-1:0];
                        end
                        idx_q <= idx_q + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready  = (state == S_IDLE);
    assign rsp_valid  = (state == S_RESP);
    assign count      = count_q;
    assign frame_size = frame_q;

endmodule
